// File: rtl/minione_core.sv
// minione_core: accumulator datapath with register file, program counter, carry/zero flags,
// shift-add multiply, HALT and a sticky illegal-opcode flag. One instruction per handshake.
module minione_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 16,
  parameter int unsigned PC_W   = 16,
  localparam int unsigned RA_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        sel,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] acc,
  output logic [PC_W-1:0]   pc,
  output logic              flag_c,
  output logic              flag_z,
  output logic              halted,
  output logic              illegal,
  input  logic [RA_W-1:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W - 1);

  localparam logic [7:0] OpLdi  = 8'd0;
  localparam logic [7:0] OpAdd  = 8'd1;
  localparam logic [7:0] OpSub  = 8'd2;
  localparam logic [7:0] OpAnd  = 8'd3;
  localparam logic [7:0] OpOr   = 8'd4;
  localparam logic [7:0] OpXor  = 8'd5;
  localparam logic [7:0] OpStr  = 8'd6;
  localparam logic [7:0] OpLdr  = 8'd7;
  localparam logic [7:0] OpAddr = 8'd8;
  localparam logic [7:0] OpSklt = 8'd9;
  localparam logic [7:0] OpMul  = 8'd10;
  localparam logic [7:0] OpJmp  = 8'd11;
  localparam logic [7:0] OpHalt = 8'd12;

  typedef enum logic [1:0] {StRun, StMul, StHalt} state_e;

  state_e                r_state;
  logic [DATA_W-1:0]     r_acc;
  logic [PC_W-1:0]       r_pc;
  logic                  r_c;
  logic                  r_z;
  logic                  r_ill;
  logic [2*DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]     r_mplier;
  logic [2*DATA_W-1:0]   r_prod;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_regs [NREG];

  state_e                w_state_nxt;
  logic [DATA_W-1:0]     w_acc_nxt;
  logic [PC_W-1:0]       w_pc_nxt;
  logic                  w_c_nxt;
  logic                  w_z_nxt;
  logic                  w_ill_nxt;
  logic [2*DATA_W-1:0]   w_mcand_nxt;
  logic [DATA_W-1:0]     w_mplier_nxt;
  logic [2*DATA_W-1:0]   w_prod_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_we;

  logic                  w_accept;
  logic [RA_W-1:0]       w_ri;
  logic [DATA_W-1:0]     w_rval;
  logic [DATA_W:0]       w_sum;
  logic [DATA_W:0]       w_diff;
  logic [DATA_W:0]       w_sum_r;
  logic [DATA_W-1:0]     w_logic;
  logic [2*DATA_W-1:0]   w_prod_add;

  assign w_accept = instr_valid && (r_state == StRun);
  assign w_ri     = op1[RA_W-1:0];
  assign w_rval   = r_regs[w_ri];
  assign w_sum    = {1'b0, op1} + {1'b0, op2};
  // Top bit of the extended difference is the borrow (op1 < op2).
  assign w_diff   = {1'b0, op1} - {1'b0, op2};
  assign w_sum_r  = {1'b0, r_acc} + {1'b0, w_rval};
  assign w_prod_add = r_prod + (r_mplier[0] ? r_mcand : '0);

  // Bitwise result for AND/OR/XOR; other opcodes ignore it.
  always_comb begin
    w_logic = '0;
    case (sel)
      OpAnd:   w_logic = op1 & op2;
      OpOr:    w_logic = op1 | op2;
      OpXor:   w_logic = op1 ^ op2;
      default: w_logic = '0;
    endcase
  end

  // Next-state logic: instruction decode in RUN, one shift-add step per cycle in MUL.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_pc_nxt     = r_pc;
    w_c_nxt      = r_c;
    w_z_nxt      = r_z;
    w_ill_nxt    = r_ill;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_prod_nxt   = r_prod;
    w_cnt_nxt    = r_cnt;
    w_we         = 1'b0;
    unique case (r_state)
      StRun: begin
        if (w_accept) begin
          w_pc_nxt = r_pc + PC_W'(1);
          case (sel)
            OpLdi: begin
              w_acc_nxt = op1;
              w_z_nxt   = (op1 == '0);
            end
            OpAdd: begin
              {w_c_nxt, w_acc_nxt} = w_sum;
              w_z_nxt = (w_sum[DATA_W-1:0] == '0);
            end
            OpSub: begin
              {w_c_nxt, w_acc_nxt} = w_diff;
              w_z_nxt = (w_diff[DATA_W-1:0] == '0);
            end
            OpAnd, OpOr, OpXor: begin
              w_acc_nxt = w_logic;
              w_c_nxt   = 1'b0;
              w_z_nxt   = (w_logic == '0);
            end
            OpStr: w_we = 1'b1;
            OpLdr: begin
              w_acc_nxt = w_rval;
              w_z_nxt   = (w_rval == '0);
            end
            OpAddr: begin
              {w_c_nxt, w_acc_nxt} = w_sum_r;
              w_z_nxt = (w_sum_r[DATA_W-1:0] == '0);
            end
            OpSklt: begin
              if (r_acc < w_rval) w_pc_nxt = r_pc + PC_W'(2);
            end
            OpMul: begin
              w_state_nxt  = StMul;
              w_mcand_nxt  = {{DATA_W{1'b0}}, op1};
              w_mplier_nxt = op2;
              w_prod_nxt   = '0;
              w_cnt_nxt    = '0;
            end
            OpJmp:  w_pc_nxt = PC_W'(op2);
            OpHalt: w_state_nxt = StHalt;
            default: w_ill_nxt = 1'b1;
          endcase
        end
      end
      StMul: begin
        w_prod_nxt   = w_prod_add;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        if (r_cnt == CntLast) begin
          w_acc_nxt   = w_prod_add[DATA_W-1:0];
          w_c_nxt     = |w_prod_add[2*DATA_W-1:DATA_W];
          w_z_nxt     = (w_prod_add[DATA_W-1:0] == '0);
          w_state_nxt = StRun;
        end
      end
      StHalt: w_state_nxt = StHalt;
      default: w_state_nxt = StRun;
    endcase
  end

  // Architectural and multiplier state; synchronous reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StRun;
      r_acc    <= '0;
      r_pc     <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_ill    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_pc     <= w_pc_nxt;
      r_c      <= w_c_nxt;
      r_z      <= w_z_nxt;
      r_ill    <= w_ill_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_prod   <= w_prod_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Register file: cleared on reset, written by STR at its accept edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[w_ri] <= r_acc;
    end
  end

  assign instr_ready = (r_state == StRun);
  assign halted      = (r_state == StHalt);
  assign acc         = r_acc;
  assign pc          = r_pc;
  assign flag_c      = r_c;
  assign flag_z      = r_z;
  assign illegal     = r_ill;
  assign rd_data     = r_regs[rd_addr];

endmodule

// File: tb/tb_minione_core.sv
// Bench for minione_core: two instances (8/16/16 and 16/4/4), vector table plus scoreboard,
// with hand-written sequences for MUL timing, HALT, illegal opcodes and reset mid-MUL.
module tb_minione_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_valid, a_ready, a_c, a_z, a_halt, a_ill;
  logic [7:0]  a_sel, a_op1, a_op2, a_acc, a_rdd;
  logic [15:0] a_pc;
  logic [3:0]  a_rd;

  logic        b_valid, b_ready, b_c, b_z, b_halt, b_ill;
  logic [7:0]  b_sel;
  logic [15:0] b_op1, b_op2, b_acc, b_rdd;
  logic [3:0]  b_pc;
  logic [1:0]  b_rd;

  minione_core #(.DATA_W(8), .NREG(16), .PC_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .instr_valid(a_valid), .instr_ready(a_ready), .sel(a_sel),
    .op1(a_op1), .op2(a_op2), .acc(a_acc), .pc(a_pc), .flag_c(a_c), .flag_z(a_z),
    .halted(a_halt), .illegal(a_ill), .rd_addr(a_rd), .rd_data(a_rdd)
  );

  minione_core #(.DATA_W(16), .NREG(4), .PC_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .instr_valid(b_valid), .instr_ready(b_ready), .sel(b_sel),
    .op1(b_op1), .op2(b_op2), .acc(b_acc), .pc(b_pc), .flag_c(b_c), .flag_z(b_z),
    .halted(b_halt), .illegal(b_ill), .rd_addr(b_rd), .rd_data(b_rdd)
  );

  typedef struct {
    logic [7:0]  sel;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [3:0]  rd;
    logic [15:0] acc;
    logic [15:0] pc;
    logic        c;
    logic        z;
    logic [15:0] rdd;
  } vec_t;

  vec_t sb[$];
  vec_t ta[$];
  vec_t tb[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input int sel, input int op1, input int op2, input int rd,
                              input int acc, input int pc, input int c, input int z,
                              input int rdd);
    vec_t v;
    v.sel = 8'(sel); v.op1 = 16'(op1); v.op2 = 16'(op2); v.rd = 4'(rd);
    v.acc = 16'(acc); v.pc = 16'(pc); v.c = c[0]; v.z = z[0]; v.rdd = 16'(rdd);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Drive one instruction, wait for acceptance and completion, then compare against the
  // scoreboard entry pushed at drive time.
  task automatic issue(input bit b, input vec_t v, input string tag);
    vec_t e;
    int k;
    sb.push_back(v);
    if (!b) begin
      a_valid = 1'b1; a_sel = v.sel; a_op1 = v.op1[7:0]; a_op2 = v.op2[7:0]; a_rd = v.rd;
    end else begin
      b_valid = 1'b1; b_sel = v.sel; b_op1 = v.op1; b_op2 = v.op2; b_rd = v.rd[1:0];
    end
    k = 0;
    while (!(b ? b_ready : a_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) timeout({tag, " accept"});
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    k = 0;
    while (!(b ? (b_ready || b_halt) : (a_ready || a_halt)) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k == 40) timeout({tag, " complete"});
    e = sb.pop_front();
    if (!b) begin
      check({tag, " acc"}, 32'(a_acc), 32'(e.acc[7:0]));
      check({tag, " pc"}, 32'(a_pc), 32'(e.pc));
      check({tag, " c"}, 32'(a_c), 32'(e.c));
      check({tag, " z"}, 32'(a_z), 32'(e.z));
      check({tag, " rd_data"}, 32'(a_rdd), 32'(e.rdd[7:0]));
    end else begin
      check({tag, " acc"}, 32'(b_acc), 32'(e.acc));
      check({tag, " pc"}, 32'(b_pc), 32'(e.pc[3:0]));
      check({tag, " c"}, 32'(b_c), 32'(e.c));
      check({tag, " z"}, 32'(b_z), 32'(e.z));
      check({tag, " rd_data"}, 32'(b_rdd), 32'(e.rdd));
    end
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    a_valid = 1'b0; a_sel = '0; a_op1 = '0; a_op2 = '0; a_rd = '0;
    b_valid = 1'b0; b_sel = '0; b_op1 = '0; b_op2 = '0; b_rd = '0;

    //          sel  op1   op2  rd  acc   pc  c  z  rdd
    ta.push_back(mk(0,   10,    0, 4,  10,   1, 0, 0,  0));
    ta.push_back(mk(6,    4,    0, 4,  10,   2, 0, 0, 10));
    ta.push_back(mk(1,  200,  100, 4,  44,   3, 1, 0, 10));
    ta.push_back(mk(2,   33,    8, 4,  25,   4, 0, 0, 10));
    ta.push_back(mk(6,    6,    0, 6,  25,   5, 0, 0, 25));
    ta.push_back(mk(7,    4,    0, 4,  10,   6, 0, 0, 10));
    ta.push_back(mk(9,    6,    0, 4,  10,   8, 0, 0, 10));
    ta.push_back(mk(2,    8,    8, 4,   0,   9, 0, 1, 10));
    ta.push_back(mk(5, 'hC3, 'hFC, 4, 'h3F, 10, 0, 0, 10));
    ta.push_back(mk(0,    3,    0, 4,   3,  11, 0, 0, 10));
    ta.push_back(mk(6,    6,    0, 6,   3,  12, 0, 0,  3));
    ta.push_back(mk(7,    4,    0, 4,  10,  13, 0, 0, 10));
    ta.push_back(mk(9,    6,    0, 4,  10,  14, 0, 0, 10));
    ta.push_back(mk(8, 'h14,    0, 4,  20,  15, 0, 0, 10));
    ta.push_back(mk(3, 'hF0, 'h0F, 4,   0,  16, 0, 1, 10));
    ta.push_back(mk(4, 'hF0, 'h0F, 4, 'hFF, 17, 0, 0, 10));
    ta.push_back(mk(8,    4,    0, 4,   9,  18, 1, 0, 10));
    ta.push_back(mk(0,    0,    0, 4,   0,  19, 1, 1, 10));
    ta.push_back(mk(11,   0,    3, 4,   0,   3, 1, 1, 10));
    ta.push_back(mk(10,  13,   11, 4, 143,   4, 0, 0, 10));
    ta.push_back(mk(10,  20,   20, 4, 'h90,  5, 1, 0, 10));

    tb.push_back(mk(0,   10,      0, 2,  10,  1, 0, 0,  0));
    tb.push_back(mk(6,    6,      0, 2,  10,  2, 0, 0, 10));
    tb.push_back(mk(1, 'hFFFF,    2, 2,   1,  3, 1, 0, 10));
    tb.push_back(mk(11,   0,     15, 2,   1, 15, 1, 0, 10));
    tb.push_back(mk(0,    0,      0, 2,   0,  0, 1, 1, 10));
    tb.push_back(mk(11,   0,     15, 2,   0, 15, 1, 1, 10));
    tb.push_back(mk(9,    2,      0, 2,   0,  1, 1, 1, 10));
    tb.push_back(mk(11,   0,  'h13, 2,   0,  3, 1, 1, 10));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset acc", 32'(a_acc), 32'd0);
    check("reset pc", 32'(a_pc), 32'd0);
    check("reset c", 32'(a_c), 32'd0);
    check("reset z", 32'(a_z), 32'd0);
    check("reset illegal", 32'(a_ill), 32'd0);
    check("reset halted", 32'(a_halt), 32'd0);
    check("reset ready", 32'(a_ready), 32'd1);

    foreach (ta[i]) issue(1'b0, ta[i], $sformatf("a%0d", i));

    // MUL with valid held high and operands swapped after accept: 8 busy cycles, one accept.
    a_valid = 1'b1; a_sel = 8'd10; a_op1 = 8'd13; a_op2 = 8'd11; a_rd = 4'd4;
    @(posedge clk);
    @(negedge clk);
    a_sel = 8'd0; a_op1 = 8'd77;
    cnt = 0;
    while (!a_ready && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    a_valid = 1'b0;
    check("mul busy cycles", 32'(cnt), 32'd8);
    check("mul held acc", 32'(a_acc), 32'd143);
    check("mul held c", 32'(a_c), 32'd0);
    check("mul held pc", 32'(a_pc), 32'd6);

    issue(1'b0, mk(12, 0, 0, 4, 143, 7, 0, 0, 10), "halt");
    check("halt halted", 32'(a_halt), 32'd1);
    check("halt ready", 32'(a_ready), 32'd0);
    a_valid = 1'b1; a_sel = 8'd0; a_op1 = 8'd55;
    repeat (3) @(negedge clk);
    a_valid = 1'b0;
    check("halt ignores acc", 32'(a_acc), 32'd143);
    check("halt ignores pc", 32'(a_pc), 32'd7);
    check("halt stays", 32'(a_halt), 32'd1);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("halt reset", 32'(a_halt), 32'd0);
    check("halt reset pc", 32'(a_pc), 32'd0);

    issue(1'b0, mk(200, 9, 9, 4, 0, 1, 0, 0, 0), "illegal");
    check("illegal flag", 32'(a_ill), 32'd1);
    issue(1'b0, mk(0, 5, 0, 4, 5, 2, 0, 0, 0), "ldi after illegal");
    check("illegal sticky", 32'(a_ill), 32'd1);
    issue(1'b0, mk(6, 4, 0, 4, 5, 3, 0, 0, 5), "str before mul");

    // Reset in the middle of a multiply: no writeback may follow.
    a_valid = 1'b1; a_sel = 8'd10; a_op1 = 8'd13; a_op2 = 8'd11;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midmul acc", 32'(a_acc), 32'd0);
    check("midmul pc", 32'(a_pc), 32'd0);
    check("midmul c", 32'(a_c), 32'd0);
    check("midmul z", 32'(a_z), 32'd0);
    check("midmul illegal", 32'(a_ill), 32'd0);
    check("midmul halted", 32'(a_halt), 32'd0);
    check("midmul ready", 32'(a_ready), 32'd1);
    check("midmul rd_data", 32'(a_rdd), 32'd0);
    repeat (10) @(negedge clk);
    check("midmul no late acc", 32'(a_acc), 32'd0);
    check("midmul no late c", 32'(a_c), 32'd0);

    foreach (tb[i]) issue(1'b1, tb[i], $sformatf("b%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
